// File: rtl/ex_mem_wb.sv
// ex_mem_wb: pipeline stage after execute.
// Registers ALU results for GPR writeback. Performs word-wide load/store over a
// ready-handshake data-memory port, and holds upstream via stall_o while an
// access is outstanding. A misaligned address or a bus timeout produces a
// one-cycle bus_err_o pulse, and that instruction is not written back.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | accepting execute-stage outputs; no memory request on the bus
// S_BUSY | memory request outstanding; ex_* ignored; timeout counter runs
module ex_mem_wb #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              mem_ena_i,
  input  logic              mem_rw_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [REG_W-1:0]  gprs_waddr_i,
  input  logic [DATA_W-1:0] gprs_wdata_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              gprs_we_o,
  output logic [REG_W-1:0]  gprs_waddr_o,
  output logic [DATA_W-1:0] gprs_wdata_o,
  output logic              bus_err_o
);

  // Wide enough to hold TIMEOUT. In practice the count never passes
  // TIMEOUT-1, because the abort fires there.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [REG_W-1:0]    r_mem_waddr;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [DATA_W-1:0]   r_dmem_addr;
  logic [DATA_W-1:0]   r_dmem_wdata;
  logic                r_gprs_we;
  logic [REG_W-1:0]    r_gprs_waddr;
  logic [DATA_W-1:0]   r_gprs_wdata;
  logic                r_bus_err;

  logic                w_aligned;

  assign w_aligned = (mem_addr_i[1:0] == 2'b00);

  // Sequencer: accept in IDLE, run the memory handshake in BUSY.
  // All outputs except stall_o are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_waddr  <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_gprs_we    <= 1'b0;
      r_gprs_waddr <= '0;
      r_gprs_wdata <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      r_gprs_we <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid_i) begin
            if (!mem_ena_i) begin
              r_gprs_we    <= (gprs_waddr_i != '0);
              r_gprs_waddr <= gprs_waddr_i;
              r_gprs_wdata <= gprs_wdata_i;
            end else if (!w_aligned) begin
              r_bus_err <= 1'b1;
            end else begin
              r_state      <= S_BUSY;
              r_cnt        <= '0;
              r_mem_waddr  <= gprs_waddr_i;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= mem_rw_i;
              r_dmem_addr  <= mem_addr_i;
              // Loads drive zero write data so the bus never shows stale store data.
              r_dmem_wdata <= mem_rw_i ? mem_data_i : '0;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ready_i) begin
            // Completion takes priority over a timeout in the same cycle.
            r_state      <= S_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            if (!r_dmem_we) begin
              r_gprs_we    <= (r_mem_waddr != '0);
              r_gprs_waddr <= r_mem_waddr;
              r_gprs_wdata <= dmem_rdata_i;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= S_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_bus_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o      = (r_state == S_BUSY);
  assign dmem_req_o   = r_dmem_req;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_wdata_o = r_dmem_wdata;
  assign gprs_we_o    = r_gprs_we;
  assign gprs_waddr_o = r_gprs_waddr;
  assign gprs_wdata_o = r_gprs_wdata;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_ex_mem_wb.sv
// Testbench for ex_mem_wb with TIMEOUT=4. It applies a table of directed
// instructions, then a few hand sequences, then randomized instructions whose
// expected outcome comes from a transaction-level model.
module tb_ex_mem_wb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_ena, mem_rw;
  logic [31:0] mem_addr, mem_data, gprs_wdata_in;
  logic [4:0]  gprs_waddr_in;
  logic        stall, dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic        dready;
  logic [31:0] drdata;
  logic        gwe;
  logic [4:0]  gwaddr;
  logic [31:0] gwdata;
  logic        berr;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_wb #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid),
    .mem_ena_i    (mem_ena),
    .mem_rw_i     (mem_rw),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_data),
    .gprs_waddr_i (gprs_waddr_in),
    .gprs_wdata_i (gprs_wdata_in),
    .stall_o      (stall),
    .dmem_req_o   (dreq),
    .dmem_we_o    (dwe),
    .dmem_addr_o  (daddr),
    .dmem_wdata_o (dwdata),
    .dmem_ready_i (dready),
    .dmem_rdata_i (drdata),
    .gprs_we_o    (gwe),
    .gprs_waddr_o (gwaddr),
    .gprs_wdata_o (gwdata),
    .bus_err_o    (berr)
  );

  always #5 clk = ~clk;

  // One instruction plus its memory behaviour (lat = BUSY cycle in which
  // ready rises; lat > TO means never) and the expected outcome.
  typedef struct {
    logic        valid;
    logic        ena;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          exp_busy;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic ena, input logic rw,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] waddr, input logic [31:0] wdata,
                              input int lat, input logic [31:0] rdata,
                              input int eb, input logic ewe, input logic [31:0] ewd,
                              input logic eerr);
    vec_t v;
    v.valid = valid; v.ena = ena; v.rw = rw; v.addr = addr; v.data = data;
    v.waddr = waddr; v.wdata = wdata; v.lat = lat; v.rdata = rdata;
    v.exp_busy = eb; v.exp_we = ewe; v.exp_wdata = ewd; v.exp_err = eerr;
    return v;
  endfunction

  // Reference outcome of one instruction, straight from the stage's rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_busy = 0; r.exp_we = 1'b0; r.exp_wdata = 32'h0; r.exp_err = 1'b0;
    if (!v.valid) begin
    end else if (!v.ena) begin
      r.exp_we = (v.waddr != 0);
      r.exp_wdata = v.wdata;
    end else if (v.addr % 4 != 0) begin
      r.exp_err = 1'b1;
    end else if (v.lat <= TO) begin
      r.exp_busy = v.lat;
      r.exp_we = !v.rw && (v.waddr != 0);
      r.exp_wdata = v.rdata;
    end else begin
      r.exp_busy = TO;
      r.exp_err = 1'b1;
    end
    return r;
  endfunction

  // Called with the DUT idle. Returns one cycle after it is idle again, with
  // ex_valid deasserted.
  task automatic apply(input vec_t v);
    ex_valid = v.valid; mem_ena = v.ena; mem_rw = v.rw; mem_addr = v.addr;
    mem_data = v.data; gprs_waddr_in = v.waddr; gprs_wdata_in = v.wdata;
    dready = 1'($urandom); drdata = $urandom;
    step();
    for (int i = 1; i <= v.exp_busy; i++) begin
      chk("busy_stall", 32'(stall), 32'd1);
      chk("busy_req", 32'(dreq), 32'd1);
      chk("busy_we", 32'(dwe), 32'(v.rw));
      chk("busy_addr", daddr, v.addr);
      chk("busy_wdata", dwdata, v.rw ? v.data : 32'h0);
      chk("busy_gwe", 32'(gwe), 32'd0);
      chk("busy_err", 32'(berr), 32'd0);
      ex_valid = 1'($urandom); mem_ena = 1'($urandom); mem_rw = 1'($urandom);
      mem_addr = $urandom; mem_data = $urandom;
      gprs_waddr_in = 5'($urandom); gprs_wdata_in = $urandom;
      dready = (i == v.lat);
      drdata = (i == v.lat) ? v.rdata : $urandom;
      step();
    end
    ex_valid = 1'b0; dready = 1'b0;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req", 32'(dreq), 32'd0);
    chk("done_gwe", 32'(gwe), 32'(v.exp_we));
    if (v.exp_we) begin
      chk("done_waddr", 32'(gwaddr), 32'(v.waddr));
      chk("done_wdata", gwdata, v.exp_wdata);
    end
    chk("done_err", 32'(berr), 32'(v.exp_err));
  endtask

  initial begin
    vec_t v;
    logic [31:0] a;

    //                valid ena rw addr          data          wa  wdata        lat rdata         busy we wdata        err
    tbl[0]  = mk(1, 0, 0, 32'h0,       32'h0,        5,  32'h1234,    0, 32'h0,        0, 1, 32'h1234,    0);
    tbl[1]  = mk(1, 1, 0, 32'h100,     32'h0,        7,  32'h0,       3, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 1, 1, 32'h200,     32'hA5A5A5A5, 9,  32'h0,       1, 32'h11111111, 1, 0, 32'h0,       0);
    tbl[3]  = mk(1, 1, 0, 32'h102,     32'h0,        3,  32'h0,       1, 32'h0,        0, 0, 32'h0,       1);
    tbl[4]  = mk(1, 1, 0, 32'h104,     32'h0,        4,  32'h0,       9, 32'h0,        4, 0, 32'h0,       1);
    tbl[5]  = mk(1, 1, 0, 32'h108,     32'h0,        6,  32'h0,       4, 32'h0BADF00D, 4, 1, 32'h0BADF00D, 0);
    tbl[6]  = mk(1, 1, 0, 32'h10C,     32'h0,        0,  32'h0,       2, 32'h12345678, 2, 0, 32'h0,       0);
    tbl[7]  = mk(0, 1, 0, 32'h300,     32'h0,        8,  32'h55,      1, 32'h0,        0, 0, 32'h0,       0);
    tbl[8]  = mk(1, 0, 0, 32'h0,       32'h0,        0,  32'hFFFF,    0, 32'h0,        0, 0, 32'h0,       0);
    tbl[9]  = mk(1, 1, 1, 32'h201,     32'h77,       2,  32'h0,       1, 32'h0,        0, 0, 32'h0,       1);
    tbl[10] = mk(1, 1, 1, 32'h204,     32'h99,       2,  32'h0,       9, 32'h0,        4, 0, 32'h0,       1);

    rst = 1'b1; ex_valid = 1'b0; mem_ena = 1'b0; mem_rw = 1'b0; mem_addr = '0;
    mem_data = '0; gprs_waddr_in = '0; gprs_wdata_in = '0; dready = 1'b0; drdata = '0;
    step(); step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dreq), 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwdata", dwdata, 32'h0);
    chk("rst_gwe", 32'(gwe), 32'd0);
    chk("rst_gwaddr", 32'(gwaddr), 32'd0);
    chk("rst_gwdata", gwdata, 32'h0);
    chk("rst_err", 32'(berr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // A store, with the next ALU op held upstream during the stall. The ALU
    // op is accepted in the first IDLE cycle and written back one cycle later.
    ex_valid = 1; mem_ena = 1; mem_rw = 1; mem_addr = 32'h208; mem_data = 32'h5A5A0000;
    gprs_waddr_in = 5'd3;
    step();
    chk("hold_req", 32'(dreq), 32'd1);
    mem_ena = 0; mem_rw = 0; gprs_waddr_in = 5'd12; gprs_wdata_in = 32'hCAFE;
    dready = 1;
    step();
    dready = 0;
    chk("hold_stall_off", 32'(stall), 32'd0);
    chk("hold_gwe_store", 32'(gwe), 32'd0);
    step();
    ex_valid = 0;
    chk("hold_gwe_alu", 32'(gwe), 32'd1);
    chk("hold_waddr", 32'(gwaddr), 32'd12);
    chk("hold_wdata", gwdata, 32'hCAFE);
    step();
    chk("hold_gwe_once", 32'(gwe), 32'd0);

    // Reset asserted mid-BUSY: the request drops, with no writeback and no error.
    ex_valid = 1; mem_ena = 1; mem_rw = 0; mem_addr = 32'h400; gprs_waddr_in = 5'd3;
    step();
    ex_valid = 0;
    chk("rbusy_req", 32'(dreq), 32'd1);
    step();
    rst = 1;
    step();
    rst = 0;
    chk("rbusy_req_off", 32'(dreq), 32'd0);
    chk("rbusy_stall", 32'(stall), 32'd0);
    chk("rbusy_daddr", daddr, 32'h0);
    chk("rbusy_gwe", 32'(gwe), 32'd0);
    chk("rbusy_err", 32'(berr), 32'd0);
    step();
    chk("rbusy_gwe_after", 32'(gwe), 32'd0);
    chk("rbusy_err_after", 32'(berr), 32'd0);
    // A full timeout after the reset shows the counter was cleared.
    apply(model(mk(1, 1, 0, 32'h404, 32'h0, 5'd4, 32'h0, 9, 32'h0, 0, 0, 32'h0, 0)));

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      v = mk(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), a, $urandom,
             5'($urandom), $urandom, int'($urandom_range(1, 6)), $urandom,
             0, 0, 32'h0, 0);
      apply(model(v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb.md
Name: ex_mem_wb

Overview:
Pipeline stage directly after the execute stage. It registers ALU results, performs word-wide load/store on a ready-handshake data-memory port, and drives the registered GPR writeback port. It asserts stall_o while a memory access is in flight so that upstream stages hold. Bus timeouts and misaligned addresses are reported with a one-cycle error pulse.

Parameters:
DATA_W, 32, data/address width
REG_W, 5, GPR index width
TIMEOUT, 255, max BUSY cycles waiting for dmem_ready_i before abort (1..2^16-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
ex_valid_i  in  1  execute-stage outputs are a real instruction (0 = bubble)
mem_ena_i  in  1  instruction accesses memory
mem_rw_i  in  1  0 = read (load), 1 = write (store)
mem_addr_i  in  DATA_W  byte address
mem_data_i  in  DATA_W  store data
gprs_waddr_i  in  REG_W  destination GPR (0 = none)
gprs_wdata_i  in  DATA_W  ALU/link result for non-memory instructions
stall_o  out  1  upstream must hold its outputs
dmem_req_o  out  1  memory request valid
dmem_we_o  out  1  request is a write
dmem_addr_o  out  DATA_W  request address
dmem_wdata_o  out  DATA_W  write data
dmem_ready_i  in  1  memory completes current request this cycle
dmem_rdata_i  in  DATA_W  read data, valid with dmem_ready_i on reads
gprs_we_o  out  1  GPR write enable
gprs_waddr_o  out  REG_W  GPR write index
gprs_wdata_o  out  DATA_W  GPR write data
bus_err_o  out  1  one-cycle pulse: timeout or misaligned access

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE, timeout counter 0. All outputs 0 from the next cycle. Reset mid-BUSY drops dmem_req_o the following cycle, with no writeback and no error.
- FSM states: IDLE and BUSY. stall_o = (state==BUSY), combinational from state only. Inputs are sampled only in IDLE.
- IDLE, ex_valid_i=0: next cycle gprs_we_o=0.
- IDLE, ex_valid_i=1, mem_ena_i=0: next cycle gprs_we_o = (gprs_waddr_i != 0), waddr/wdata = inputs. One-cycle latency; stays IDLE.
- IDLE, ex_valid_i=1, mem_ena_i=1, mem_addr_i[1:0] != 0: no request, no writeback; bus_err_o=1 the next cycle; stays IDLE.
- IDLE, ex_valid_i=1, mem_ena_i=1, aligned:
  - latch addr, data, rw, waddr; go to BUSY; counter cleared.
  - next cycle gprs_we_o=0.
- BUSY:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o, dmem_wdata_o stable from latched values.
  - dmem_wdata_o=0 for reads.
  - Ignore ex_* inputs (upstream is holding the next instruction).
- BUSY, dmem_ready_i=1:
  - go to IDLE.
  - Read: next cycle gprs_we_o = (latched waddr != 0), gprs_wdata_o = dmem_rdata_i.
  - Write: gprs_we_o=0.
- BUSY, dmem_ready_i=0: counter increments.
  - When counter reaches TIMEOUT-1 in this cycle: go to IDLE, bus_err_o=1 the next cycle, no writeback.
  - dmem_ready_i=1 in the same cycle as the timeout: completion wins, no error.
- Access latency: accept at cycle N, request in N+1; ready at M gives writeback and stall_o=0 at M+1, and the held instruction is accepted at M+1.
- dmem_req_o is 0 in IDLE. Memory must not see back-to-back requests without an intervening IDLE cycle.
- Register-file outputs are registered. gprs_we_o is never 1 with gprs_waddr_o=0.
- Counter width: ceil(log2(TIMEOUT+1)) bits; no wrap (capped by the abort).

Test Plan:
- Reset, then ALU op (valid=1, mem_ena=0, waddr=5, wdata=0x1234) at cycle 1 -> cycle 2 gprs_we=1, waddr=5, wdata=0x1234; stall_o stays 0.
- Load addr=0x100, waddr=7, memory ready after 3 cycles with rdata=0xDEADBEEF -> dmem_req=1, we=0, addr=0x100 for 3 cycles; stall_o=1 over the same cycles; next cycle gprs_we=1, waddr=7, wdata=0xDEADBEEF.
- Store addr=0x200, data=0xA5A5A5A5, ready after 1 cycle -> one request cycle with we=1 and wdata=0xA5A5A5A5; gprs_we stays 0. Following ALU op held during stall, written back the cycle after return to IDLE.
- Misaligned load addr=0x102 -> no dmem_req; bus_err pulse 1 cycle; gprs_we=0.
- TIMEOUT=4, load with ready never asserted -> req high 4 cycles, then IDLE, bus_err 1 cycle, no writeback. Repeat with ready in the 4th cycle -> writeback, no error.
- rst asserted during BUSY, and load to waddr=0 -> req drops next cycle with outputs 0; x0 load completes with gprs_we=0.
